// File: rtl/spi_slave_if.sv
// Pin and word-side bundle of the SPI slave: serial pins plus the parallel
// transmit/receive words and status pulses.
interface spi_slave_if #(
  parameter int WIDTH = 40
);
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             cs;
  logic             sck;
  logic             mosi;
  logic             miso;

  modport slave (
    input  tx_data, cs, sck, mosi,
    output rx_data, rx_valid, busy, frame_err, overrun, miso
  );

  modport master (
    output tx_data, cs, sck, mosi,
    input  rx_data, rx_valid, busy, frame_err, overrun, miso
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fixed WIDTH-bit frames, oversampled by clk. All pins are
// synchronized; edges come from the last sync stage vs. one extra delayed copy.
module spi_slave #(
  parameter int WIDTH       = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);
  localparam logic [5:0] CNT_FULL = 6'(WIDTH);
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, WAIT_CS} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  logic [WIDTH-1:0] tx_sr, rx_sr, rx_data;
  logic [5:0]       cnt;
  logic             miso, rx_valid, frame_err, overrun, ovr_done;

  logic load, do_rx, do_tx, done, ferr, ovr;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign cs_rise  =  cs_s  & ~cs_d;
  assign cs_fall  = ~cs_s  &  cs_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    do_rx    = 1'b0;
    do_tx    = 1'b0;
    done     = 1'b0;
    ferr     = 1'b0;
    ovr      = 1'b0;
    case (state)
      // vld_pipe keeps the reset-loaded sync values from faking an idle cs
      IDLE:    if (vld_pipe[SYNC_STAGES] && cs_s) state_nx = ARMED;
      ARMED:   if (cs_fall) begin
                 load     = 1'b1;
                 state_nx = SHIFT;
               end
      SHIFT:   if (cnt == CNT_FULL) begin
                 // completion wins over a cs rise that arrived with the last bit
                 done     = 1'b1;
                 state_nx = cs_s ? ARMED : WAIT_CS;
               end else begin
                 do_rx = sck_rise;
                 do_tx = sck_fall;
                 if (cs_rise && !(sck_rise && cnt == CNT_LAST)) begin
                   ferr     = 1'b1;
                   state_nx = ARMED;
                 end
               end
      WAIT_CS: begin
                 ovr = sck_rise & ~ovr_done;
                 if (cs_rise) state_nx = ARMED;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      vld_pipe  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      cnt       <= '0;
      miso      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      ovr_done  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  bus.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      rx_valid  <= done;
      frame_err <= ferr;
      overrun   <= ovr;

      if (load) begin
        tx_sr    <= bus.tx_data;
        rx_sr    <= '0;
        cnt      <= '0;
        ovr_done <= 1'b0;
      end
      if (do_rx) begin
        rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
        cnt   <= cnt + 6'd1;
      end
      if (do_tx) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      if (done)  rx_data <= rx_sr;
      if (ovr)   ovr_done <= 1'b1;

      if (state_nx != SHIFT && state_nx != WAIT_CS) miso <= 1'b0;
      else if (load)                                miso <= bus.tx_data[WIDTH-1];
      else if (do_tx)                               miso <= tx_sr[WIDTH-2];
      else if (state == WAIT_CS && sck_fall)        miso <= 1'b0;
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
  assign bus.miso      = miso;
  assign bus.busy      = (state == SHIFT) || (state == WAIT_CS);
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master with randomized words, checked against
// expectations derived from the frame rules (bits sent, words captured).
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int WIDTH = 40;
  localparam int HALF  = 640;  // 781.25 kHz sck, 64 clk per bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  spi_slave_if #(.WIDTH(WIDTH)) bus ();
  spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int n_fe  = 0;
  int n_ov  = 0;
  logic [WIDTH-1:0] rxq[$];
  logic [WIDTH-1:0] exp_rx;

  always @(negedge clk) begin
    if (bus.rx_valid)  rxq.push_back(bus.rx_data);
    if (bus.frame_err) n_fe++;
    if (bus.overrun)   n_ov++;
  end

  // cs_mode: 0 raise cs after the frame, 1 raise cs with the last sck rise, 2 leave low
  task automatic spi_xfer(input int nbits, input logic [63:0] bits, input int cs_mode,
                          input logic [WIDTH-1:0] tx_mid, output logic [63:0] rd,
                          output logic mid_busy);
    rd = '0;
    mid_busy = 1'b0;
    @(negedge clk);
    bus.cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = bits[nbits-1-i];
      #(HALF);
      rd = {rd[62:0], bus.miso};
      if (i == nbits/2) begin
        mid_busy    = bus.busy;
        bus.tx_data = tx_mid;
      end
      bus.sck = 1'b1;
      if (cs_mode == 1 && i == nbits-1) bus.cs = 1'b1;
      #(HALF);
      bus.sck = 1'b0;
    end
    #(HALF);
    if (cs_mode == 0) bus.cs = 1'b1;
    bus.mosi = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[WIDTH-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.cs = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0; bus.tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.rx_data !== '0) begin bad++; $display("FAIL reset_rx_data got=%h want=0", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", bus.miso); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    exp_rx = '0;
  endtask

  task automatic test_normal();
    logic [63:0] rd; logic mb; int fe0;
    logic [WIDTH-1:0] tx;
    tx = 40'hA50F3C817E;
    bus.tx_data = tx;
    rxq.delete(); fe0 = n_fe;
    spi_xfer(40, 64'h8300000000, 0, tx, rd, mb);
    repeat (10) @(negedge clk);
    exp_rx = 40'h8300000000;
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL normal_pulses got=%0d want=1", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL normal_rx got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (rd[WIDTH-1:0] !== tx) begin bad++; $display("FAIL normal_miso got=%h want=%h", rd[WIDTH-1:0], tx); end
    total++; if (mb !== 1'b1) begin bad++; $display("FAIL normal_busy_mid got=%b want=1", mb); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL normal_busy_end got=%b want=0", bus.busy); end
    total++; if (n_fe - fe0 != 0) begin bad++; $display("FAIL normal_frame_err got=%0d want=0", n_fe - fe0); end
    total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL normal_miso_idle got=%b want=0", bus.miso); end
  endtask

  task automatic test_short();
    logic [63:0] rd; logic mb; int fe0;
    logic [WIDTH-1:0] w;
    w = rnd_word();
    rxq.delete(); fe0 = n_fe;
    spi_xfer(20, {44'b0, w[19:0]}, 0, bus.tx_data, rd, mb);
    repeat (10) @(negedge clk);
    total++; if (n_fe - fe0 != 1) begin bad++; $display("FAIL short_frame_err got=%0d want=1", n_fe - fe0); end
    total++; if (rxq.size() != 0) begin bad++; $display("FAIL short_pulses got=%0d want=0", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL short_rx_held got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL short_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_overrun();
    logic [63:0] rd; logic mb; int fe0, ov0;
    logic [WIDTH-1:0] tx;
    tx = rnd_word();
    bus.tx_data = tx;
    rxq.delete(); fe0 = n_fe; ov0 = n_ov;
    spi_xfer(41, {23'b0, {WIDTH{1'b1}}, 1'b0}, 0, tx, rd, mb);
    repeat (10) @(negedge clk);
    exp_rx = {WIDTH{1'b1}};
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL ovr_rx got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (n_ov - ov0 != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", n_ov - ov0); end
    total++; if (rd[0] !== 1'b0) begin bad++; $display("FAIL ovr_miso_bit41 got=%b want=0", rd[0]); end
    total++; if (rd[WIDTH:1] !== tx) begin bad++; $display("FAIL ovr_miso got=%h want=%h", rd[WIDTH:1], tx); end
    total++; if (n_fe - fe0 != 0) begin bad++; $display("FAIL ovr_frame_err got=%0d want=0", n_fe - fe0); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic mb; int fe0;
    logic [WIDTH-1:0] w, tx;
    w = rnd_word();
    rxq.delete(); fe0 = n_fe;
    spi_xfer(10, {24'b0, w}, 2, bus.tx_data, rd, mb);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    spi_xfer(30, {24'b0, w}, 0, bus.tx_data, rd, mb);
    repeat (10) @(negedge clk);
    exp_rx = '0;
    total++; if (rxq.size() != 0) begin bad++; $display("FAIL rstmid_pulses got=%0d want=0", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL rstmid_rx got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (mb !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", mb); end
    total++; if (n_fe - fe0 != 0) begin bad++; $display("FAIL rstmid_frame_err got=%0d want=0", n_fe - fe0); end
    w = rnd_word(); tx = rnd_word();
    bus.tx_data = tx;
    rxq.delete();
    spi_xfer(40, {24'b0, w}, 0, tx, rd, mb);
    repeat (10) @(negedge clk);
    exp_rx = w;
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL rstmid_next_pulses got=%0d want=1", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL rstmid_next_rx got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (rd[WIDTH-1:0] !== tx) begin bad++; $display("FAIL rstmid_next_miso got=%h want=%h", rd[WIDTH-1:0], tx); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd1, rd2; logic mb;
    logic [WIDTH-1:0] ta, tb, tc;
    ta = rnd_word(); tb = rnd_word(); tc = rnd_word();
    bus.tx_data = ta;
    rxq.delete();
    spi_xfer(40, 64'h0000000001, 0, tb, rd1, mb);
    repeat (3) @(negedge clk);
    spi_xfer(40, 64'h8000000000, 0, tc, rd2, mb);
    repeat (10) @(negedge clk);
    exp_rx = 40'h8000000000;
    total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", rxq.size()); end
    if (rxq.size() == 2) begin
      total++; if (rxq[0] !== 40'h0000000001) begin bad++; $display("FAIL b2b_rx0 got=%h want=%h", rxq[0], 40'h0000000001); end
      total++; if (rxq[1] !== exp_rx) begin bad++; $display("FAIL b2b_rx1 got=%h want=%h", rxq[1], exp_rx); end
    end
    total++; if (rd1[WIDTH-1:0] !== ta) begin bad++; $display("FAIL b2b_miso0 got=%h want=%h", rd1[WIDTH-1:0], ta); end
    total++; if (rd2[WIDTH-1:0] !== tb) begin bad++; $display("FAIL b2b_miso1 got=%h want=%h", rd2[WIDTH-1:0], tb); end
  endtask

  task automatic test_boundary();
    logic [63:0] rd; logic mb; int fe0;
    logic [WIDTH-1:0] w, tx;
    w = rnd_word(); tx = rnd_word();
    bus.tx_data = tx;
    rxq.delete(); fe0 = n_fe;
    spi_xfer(40, {24'b0, w}, 1, tx, rd, mb);
    repeat (10) @(negedge clk);
    exp_rx = w;
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL bound_pulses got=%0d want=1", rxq.size()); end
    total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL bound_rx got=%h want=%h", bus.rx_data, exp_rx); end
    total++; if (n_fe - fe0 != 0) begin bad++; $display("FAIL bound_frame_err got=%0d want=0", n_fe - fe0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bound_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_random();
    logic [63:0] rd; logic mb;
    logic [WIDTH-1:0] w, tx;
    for (int k = 0; k < 3; k++) begin
      w = rnd_word(); tx = rnd_word();
      bus.tx_data = tx;
      rxq.delete();
      spi_xfer(40, {24'b0, w}, 0, rnd_word(), rd, mb);
      repeat (6) @(negedge clk);
      exp_rx = w;
      total++; if (rxq.size() != 1) begin bad++; $display("FAIL rand%0d_pulses got=%0d want=1", k, rxq.size()); end
      total++; if (bus.rx_data !== exp_rx) begin bad++; $display("FAIL rand%0d_rx got=%h want=%h", k, bus.rx_data, exp_rx); end
      total++; if (rd[WIDTH-1:0] !== tx) begin bad++; $display("FAIL rand%0d_miso got=%h want=%h", k, rd[WIDTH-1:0], tx); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
